serial_sub: RTL
===============

Name: serial_sub

Overview:
- Bit-serial N-bit subtractor; the inverse operation of the team's full-adder datapath.
- Computes D = A - B - Bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Start/Busy/Done handshake; intended as a low-area arithmetic slice alongside the adder blocks.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only when the FSM is in IDLE.
- A  input  WIDTH  minuend; latched on the accepted Start edge.
- B  input  WIDTH  subtrahend; latched on the accepted Start edge.
- Bin  input  1  borrow-in; latched on the accepted Start edge.
- Busy  output  1  high while an operation is in progress (RUN state).
- Done  output  1  one-cycle pulse marking a completed result.
- D  output  WIDTH  difference; registered, holds until the next completion.
- Bout  output  1  borrow-out of the MSB (unsigned A < B + Bin).
- Ovf  output  1  signed two's-complement overflow.

Behaviour:
- Clocking and reset: one clock, Clk. Reset Rst is synchronous and active-high.
- Reset values: state=IDLE, Busy=0, Done=0, D=0, Bout=0, Ovf=0, bit counter=0, internal borrow=0.
- FSM states: IDLE and RUN.
- IDLE -> RUN: on an edge where Start=1.
  - Latch A and B into internal shift registers.
  - Latch Bin into the borrow flop.
  - Clear the counter.
  - Busy=1 from the next cycle.
- RUN, each edge, with a/b = the current LSBs of the shift registers and br = the borrow flop:
  - Difference bit d = a ^ b ^ br.
  - br_next = (~a & b) | (~(a ^ b) & br).
  - d shifts into the MSB of the internal result register; operand registers shift right; counter increments.
- RUN -> IDLE: on the edge where counter = WIDTH-1 (the WIDTH-th RUN edge).
  - D <= full result.
  - Bout <= br_next.
  - Ovf <= (A[MSB] != B[MSB]) & (D[MSB] != A[MSB]), using the latched operands.
  - Done=1 for exactly that following cycle; Busy=0.
- Latency: Start edge plus WIDTH edges. Done is visible WIDTH+1 cycles after Start is first presented.
- D/Bout/Ovf change only on completion or reset. Intermediate shift values are never visible on D.
- Start while Busy=1: ignored. No queuing; the in-flight operation is unaffected.
- Start high in the Done cycle: accepted, since the FSM is already in IDLE. This gives back-to-back operation with no dead cycle. Done still pulses only once for the previous result.
- Start held high continuously: a new operation starts every WIDTH+1 cycles.
- Operand changes during RUN: no effect, because operands are latched.
- Rst mid-operation: the operation is aborted and all outputs return to reset values on that edge. No Done is issued for the aborted operation.
- Rst and Start on the same edge: Rst wins; Start is not accepted.
- Wrap-around: the result is modulo 2^WIDTH. The borrow past the MSB is reported only via Bout.

Test Plan:
- Reset, WIDTH=8: assert Rst 2 cycles -> Busy=0, Done=0, D=0x00, Bout=0, Ovf=0.
- A=0x05, B=0x03, Bin=0, Start pulse -> Busy high 8 cycles; Done pulses on the 9th edge; D=0x02, Bout=0, Ovf=0.
- A=0x03, B=0x05 -> D=0xFE, Bout=1, Ovf=0.
- A=0x80, B=0x01 -> D=0x7F, Bout=0, Ovf=1.
- A=0x00, B=0x00, Bin=1 -> D=0xFF, Bout=1, Ovf=0.
- Handshake edge cases:
  - Start re-pulsed mid-RUN with A=0xFF -> ignored; original result reported.
  - Start asserted in the Done cycle -> second result follows exactly 9 cycles later.
  - Rst at RUN cycle 4 -> no Done; outputs 0; the next Start completes normally.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor: D = A - B - Bin, one bit per clock, LSB first.
// One full-subtractor cell plus a registered borrow; Start/Busy/Done handshake.
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             ovf_q;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] res_d;
  logic             last_d;

  // Full-subtractor cell on the current operand LSBs and the running borrow
  always_comb begin
    a_bit  = a_sh_q[0];
    b_bit  = b_sh_q[0];
    d_bit  = a_bit ^ b_bit ^ br_q;
    br_d   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    res_d  = {d_bit, res_q[WIDTH-1:1]};
    last_d = (cnt_q == CW'(WIDTH - 1));
  end

  // Control FSM with datapath shift registers and registered outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            a_sh_q  <= A;
            b_sh_q  <= B;
            a_msb_q <= A[WIDTH-1];
            b_msb_q <= B[WIDTH-1];
            br_q    <= Bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          res_q  <= res_d;
          br_q   <= br_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last_d) begin
            // the final difference bit is the result MSB, so Ovf uses d_bit directly
            d_q     <= res_d;
            bout_q  <= br_d;
            ovf_q   <= (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign D    = d_q;
  assign Bout = bout_q;
  assign Ovf  = ovf_q;

endmodule
